// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch stage
package fetch_pkg;
  typedef enum logic [1:0] {IDLE, REQ, HOLD, KILL} fetch_state_t;
  localparam int INSN_BYTES = 4;
endpackage

// File: rtl/pc_reg.sv
// pc_reg: program counter with sync active-low reset and sequential/redirect load
module pc_reg
  import fetch_pkg::*;
#(
  parameter int N = 64,
  parameter logic [N-1:0] RESET_PC = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         sel_redirect,
  input  logic [N-1:0] redirect_pc,
  output logic [N-1:0] pc
);
  always_ff @(posedge clk)
    if (!reset) pc <= RESET_PC;
    else if (load) pc <= sel_redirect ? redirect_pc : pc + N'(INSN_BYTES);
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: LEGv8 fetch stage, one outstanding imem request, IF/ID holding register
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int N = 64,
  parameter int INSN_W = 32,
  parameter logic [N-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              redirect_en,
  input  logic [N-1:0]      redirect_pc,
  output logic              imem_req,
  output logic [N-1:0]      imem_addr,
  input  logic              imem_ack,
  input  logic [INSN_W-1:0] imem_rdata,
  output logic              if_valid,
  output logic [N-1:0]      if_pc,
  output logic [INSN_W-1:0] if_instr
);
  fetch_state_t state, state_n;
  logic pc_load, cap, clr;
  always_ff @(posedge clk)
    if (!reset) state <= IDLE;
    else state <= state_n;
  // KILL absorbs the ack of a request squashed by redirect before it returned
  always_comb begin
    state_n = state == IDLE ? REQ :
              state == REQ  ? (redirect_en ? (imem_ack ? REQ : KILL) : (imem_ack ? HOLD : REQ)) :
              state == HOLD ? ((redirect_en || !stall) ? REQ : HOLD) :
                              (imem_ack ? REQ : KILL);
    pc_load = (redirect_en && state != IDLE) || (state == REQ && imem_ack);
    cap     = state == REQ && imem_ack && !redirect_en;
    clr     = state == HOLD && (redirect_en || !stall);
  end
  always_ff @(posedge clk)
    if (!reset) begin
      if_valid <= 1'b0;
      if_pc    <= '0;
      if_instr <= '0;
    end else if (cap) begin
      if_valid <= 1'b1;
      if_pc    <= imem_addr;
      if_instr <= imem_rdata;
    end else if (clr) begin
      if_valid <= 1'b0;
    end
  assign imem_req = state == REQ;
  pc_reg #(.N(N), .RESET_PC(RESET_PC)) u_pc (
    .clk(clk),
    .reset(reset),
    .load(pc_load),
    .sel_redirect(redirect_en),
    .redirect_pc(redirect_pc),
    .pc(imem_addr)
  );
endmodule
